// File: rtl/gasoline_spawner.sv
// gasoline_spawner: spawns falling gasoline cans into pseudo-random lanes,
// drives the mover's active-low reset and draw gate, tracks missed cans and
// owns the player fuel gauge (frame-based drain, refill on pickup).
module gasoline_spawner #(
  parameter logic [10:0] LANE_X0            = 11'd200,
  parameter logic [10:0] LANE_X1            = 11'd264,
  parameter logic [10:0] LANE_X2            = 11'd328,
  parameter logic [10:0] LANE_X3            = 11'd392,
  parameter int unsigned SPAWN_DELAY_FRAMES = 60,
  parameter int unsigned FUEL_MAX           = 100,
  parameter int unsigned FUEL_REFILL        = 25,
  parameter int unsigned FUEL_DRAIN_FRAMES  = 30,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        gameActive,
  input  logic        collected,
  input  logic        failed,
  output logic [10:0] initialX,
  output logic        moverResetN,
  output logic        gasolineVisible,
  output logic [7:0]  fuelLevel,
  output logic        fuelEmpty,
  output logic [3:0]  missCount
);

  localparam logic [7:0]  SPAWN_DELAY = 8'(SPAWN_DELAY_FRAMES);
  localparam logic [7:0]  DRAIN_DIV   = 8'(FUEL_DRAIN_FRAMES);
  localparam logic [7:0]  FUEL_FULL   = 8'(FUEL_MAX);
  localparam logic [8:0]  REFILL_AMT  = 9'(FUEL_REFILL);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPAWN,
    S_LAUNCH,
    S_ACTIVE,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  drain_q, drain_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  fuel_q, fuel_d;
  logic [3:0]  miss_q, miss_d;
  logic [10:0] initx_q, initx_d;
  logic        mover_q, mover_d;
  logic        vis_q, vis_d;
  logic        empty_q, empty_d;

  logic        spawn_hit;
  logic        drain_en;
  logic        drain_tick;
  logic        refill;
  logic [8:0]  fuel_sum;

  assign spawn_hit  = startOfFrame && ((frame_q + 8'd1) == SPAWN_DELAY);
  assign drain_en   = gameActive && (fuel_q != 8'd0) && startOfFrame;
  assign drain_tick = drain_en && ((drain_q + 8'd1) == DRAIN_DIV);
  assign refill     = gameActive && (state_q == S_ACTIVE) && collected;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a low gameActive parks the block from any state.
  always_comb begin
    state_d = state_q;
    if (!gameActive) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       state_d = S_WAIT_SPAWN;
        S_WAIT_SPAWN: if (spawn_hit) state_d = S_LAUNCH;
        S_LAUNCH:     state_d = S_ACTIVE;
        S_ACTIVE:     if (collected || failed) state_d = S_CLEAR;
        S_CLEAR:      state_d = S_WAIT_SPAWN;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    frame_d = frame_q;
    case (state_q)
      S_WAIT_SPAWN: if (gameActive && startOfFrame) frame_d = frame_q + 8'd1;
      S_IDLE, S_LAUNCH, S_CLEAR: frame_d = '0;
      default: frame_d = frame_q;
    endcase

    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    drain_d = drain_q;
    if (drain_en) drain_d = drain_tick ? 8'd0 : drain_q + 8'd1;

    // Drain and refill combine in 9 bits before saturating at full tank.
    fuel_sum = {1'b0, fuel_q} - {8'd0, drain_tick} + (refill ? REFILL_AMT : 9'd0);
    fuel_d   = (fuel_sum > {1'b0, FUEL_FULL}) ? FUEL_FULL : fuel_sum[7:0];

    miss_d = miss_q;
    if (gameActive && (state_q == S_ACTIVE) && failed && !collected && (miss_q != 4'hF))
      miss_d = miss_q + 4'd1;

    initx_d = initx_q;
    if ((state_q == S_LAUNCH) && (state_d == S_ACTIVE)) begin
      case (lfsr_q[1:0])
        2'd0: initx_d = LANE_X0;
        2'd1: initx_d = LANE_X1;
        2'd2: initx_d = LANE_X2;
        default: initx_d = LANE_X3;
      endcase
    end

    mover_d = (state_d == S_ACTIVE);
    vis_d   = (state_d == S_ACTIVE);
    empty_d = (fuel_d == 8'd0);
  end

  // Datapath registers; reset overrides any concurrent event.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      drain_q <= '0;
      lfsr_q  <= SEED;
      fuel_q  <= FUEL_FULL;
      miss_q  <= '0;
      initx_q <= LANE_X0;
      mover_q <= 1'b0;
      vis_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      drain_q <= drain_d;
      lfsr_q  <= lfsr_d;
      fuel_q  <= fuel_d;
      miss_q  <= miss_d;
      initx_q <= initx_d;
      mover_q <= mover_d;
      vis_q   <= vis_d;
      empty_q <= empty_d;
    end
  end

  assign initialX        = initx_q;
  assign moverResetN     = mover_q;
  assign gasolineVisible = vis_q;
  assign fuelLevel       = fuel_q;
  assign fuelEmpty       = empty_q;
  assign missCount       = miss_q;

endmodule

// File: tb/tb_gasoline_spawner.sv
// Testbench for gasoline_spawner: directed scenarios followed by random play,
// all compared against a behavioural model of the spawner rules.
module tb_gasoline_spawner;

  localparam int SPAWN  = 3;
  localparam int DRAIN  = 2;
  localparam int FMAX   = 100;
  localparam int REFILL = 25;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst, sof, ga, col, fail;
  logic [10:0] initialX;
  logic        moverResetN, gasolineVisible, fuelEmpty;
  logic [7:0]  fuelLevel;
  logic [3:0]  missCount;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  string       m_mode;
  int          m_frames, m_drain, m_fuel, m_miss;
  logic [15:0] m_lfsr;
  logic [10:0] m_x;

  gasoline_spawner #(
    .SPAWN_DELAY_FRAMES(SPAWN),
    .FUEL_MAX(FMAX),
    .FUEL_REFILL(REFILL),
    .FUEL_DRAIN_FRAMES(DRAIN),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(rst),
    .startOfFrame(sof),
    .gameActive(ga),
    .collected(col),
    .failed(fail),
    .initialX(initialX),
    .moverResetN(moverResetN),
    .gasolineVisible(gasolineVisible),
    .fuelLevel(fuelLevel),
    .fuelEmpty(fuelEmpty),
    .missCount(missCount)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [10:0] lane(input logic [1:0] idx);
    case (idx)
      2'd0: return 11'd200;
      2'd1: return 11'd264;
      2'd2: return 11'd328;
      default: return 11'd392;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [15:0] nl;
    int tick, sum;
    if (rst) begin
      m_mode = "IDLE"; m_frames = 0; m_drain = 0; m_fuel = FMAX;
      m_miss = 0; m_x = 11'd200; m_lfsr = SEED;
      return;
    end
    nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    tick = 0;
    if (ga && m_fuel > 0 && sof) begin
      m_drain++;
      if (m_drain == DRAIN) begin m_drain = 0; tick = 1; end
    end
    sum = m_fuel - tick;
    if (ga && m_mode == "ACTIVE" && col) sum += REFILL;
    if (sum > FMAX) sum = FMAX;
    m_fuel = sum;
    if (ga && m_mode == "ACTIVE" && fail && !col && m_miss < 15) m_miss++;
    if (!ga) m_mode = "IDLE";
    else if (m_mode == "IDLE") begin m_frames = 0; m_mode = "WAIT"; end
    else if (m_mode == "WAIT") begin
      if (sof) begin
        m_frames++;
        if (m_frames == SPAWN) m_mode = "LAUNCH";
      end
    end
    else if (m_mode == "LAUNCH") begin
      m_x = lane(m_lfsr[1:0]); m_frames = 0; m_mode = "ACTIVE";
    end
    else if (m_mode == "ACTIVE") begin
      if (col || fail) m_mode = "CLEAR";
    end
    else begin m_frames = 0; m_mode = "WAIT"; end
    m_lfsr = nl;
  endtask

  task automatic check_all();
    check("initialX", 16'(initialX), 16'(m_x));
    check("moverResetN", 16'(moverResetN), 16'(m_mode == "ACTIVE"));
    check("gasolineVisible", 16'(gasolineVisible), 16'(m_mode == "ACTIVE"));
    check("fuelLevel", 16'(fuelLevel), 16'(m_fuel));
    check("fuelEmpty", 16'(fuelEmpty), 16'(m_fuel == 0));
    check("missCount", 16'(missCount), 16'(m_miss));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Issue frames every 10 clocks until the mover is released (bounded).
  task automatic run_until_active(input string tag);
    bit found = 0;
    for (int c = 0; c < 400; c++) begin
      if (moverResetN === 1'b1) begin found = 1; break; end
      sof = (c % 10 == 0);
      step();
    end
    sof = 0;
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s: timeout waiting for launch observed 0 expected 1", tag);
    end
  endtask

  initial begin
    bit lane_ok;
    int held;
    bit found;
    rst = 1; sof = 0; ga = 0; col = 0; fail = 0;
    step(); step();
    check("rst_initialX", 16'(initialX), 16'd200);
    check("rst_fuel", 16'(fuelLevel), 16'(FMAX));
    check("rst_mover", 16'(moverResetN), 16'd0);
    rst = 0;

    // Basic launch: three frames, 10 clocks apart
    ga = 1; step();
    for (int k = 1; k <= SPAWN; k++) begin
      sof = 1; step(); sof = 0;
      if (k < SPAWN) repeat (9) step();
    end
    check("launch_cycle_mover", 16'(moverResetN), 16'd0);
    step();
    check("launch_n2_mover", 16'(moverResetN), 16'd1);
    check("launch_n2_vis", 16'(gasolineVisible), 16'd1);
    lane_ok = initialX inside {11'd200, 11'd264, 11'd328, 11'd392};
    check("lane_set", 16'(lane_ok), 16'd1);

    // Pickup refill saturates at full tank (fuel is 99 here)
    col = 1; step(); col = 0;
    check("refill_sat", 16'(fuelLevel), 16'(FMAX));
    check("refill_vis_drop", 16'(gasolineVisible), 16'd0);
    run_until_active("relaunch");

    // Sixteen misses saturate the counter at 15
    for (int i = 0; i < 16; i++) begin
      fail = 1; step(); fail = 0;
      check("miss_count", 16'(missCount), 16'((i + 1 > 15) ? 15 : i + 1));
      run_until_active("miss_relaunch");
    end

    // Collected and failed together count as a pickup only
    held = m_fuel;
    col = 1; fail = 1; step(); col = 0; fail = 0;
    check("collision_miss", 16'(missCount), 16'd15);
    check("collision_fuel", 16'(fuelLevel), 16'((held + REFILL > FMAX) ? FMAX : held + REFILL));
    run_until_active("collision_relaunch");

    // Drain to empty while the can stays active, then confirm no wrap
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (fuelEmpty === 1'b1) begin found = 1; break; end
      sof = 1; step(); sof = 0; step();
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL drain_timeout: observed 0 expected 1");
    end
    repeat (6) begin sof = 1; step(); sof = 0; step(); end
    check("drain_floor", 16'(fuelLevel), 16'd0);
    check("drain_empty", 16'(fuelEmpty), 16'd1);

    // Pickup at empty, then a drain frame coinciding with pickup at fuel 5
    col = 1; step(); col = 0;
    check("refill_from_zero", 16'(fuelLevel), 16'd25);
    run_until_active("refill_relaunch");
    found = 0;
    for (int c = 0; c < 400; c++) begin
      if (m_fuel == 5 && m_drain == DRAIN - 1) begin found = 1; break; end
      sof = 1; step(); sof = 0; step();
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL fuel5_timeout: observed 0 expected 1");
    end
    sof = 1; col = 1; step(); sof = 0; col = 0;
    check("drain_plus_refill", 16'(fuelLevel), 16'd29);
    check("drain_plus_refill_empty", 16'(fuelEmpty), 16'd0);

    // Park in ACTIVE, fuel held while parked
    run_until_active("park_launch");
    held = m_fuel;
    ga = 0; step();
    check("park_mover", 16'(moverResetN), 16'd0);
    repeat (4) begin sof = 1; step(); sof = 0; step(); end
    check("park_fuel_held", 16'(fuelLevel), 16'(held));

    // Reset mid-WAIT_SPAWN with concurrent events
    ga = 1; step(); sof = 1; step(); sof = 0; step();
    rst = 1; sof = 1; col = 1; fail = 1; step();
    rst = 0; sof = 0; col = 0; fail = 0;
    check("rst2_initialX", 16'(initialX), 16'd200);
    check("rst2_mover", 16'(moverResetN), 16'd0);
    check("rst2_vis", 16'(gasolineVisible), 16'd0);
    check("rst2_fuel", 16'(fuelLevel), 16'(FMAX));
    check("rst2_empty", 16'(fuelEmpty), 16'd0);
    check("rst2_miss", 16'(missCount), 16'd0);

    // Random play
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) ga = ~ga;
      rst  = ($urandom_range(0, 999) == 0);
      sof  = ($urandom_range(0, 3) == 0);
      col  = ($urandom_range(0, 24) == 0);
      fail = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gasoline_spawner.md
# gasoline_spawner

Upstream controller for the falling-gasoline mover. Counts frames between pickups, picks a pseudo-random lane X for each new can, launches the mover by pulsing its active-low reset, and removes the can when the player collects it or it falls off the bottom (mover `failed`). Also owns the player fuel gauge: drains it on a frame timebase and refills it on each pickup. Outputs drive the mover, the gasoline draw gate and the HUD fuel bar.

## Interface
Parameters:
- `LANE_X0..LANE_X3`, default 200 / 264 / 328 / 392: 11-bit X values, driven verbatim on `initialX`.
- `SPAWN_DELAY_FRAMES`, default 60: frames from clear/start to the next launch (1..255).
- `FUEL_MAX`, default 100: full-tank value (1..255).
- `FUEL_REFILL`, default 25: units added per pickup.
- `FUEL_DRAIN_FRAMES`, default 30: frames per 1-unit drain (1..255).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A seed of 0 is replaced by 1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle pulse per frame.
- `gameActive`, in, 1: level running. When low, the block parks.
- `collected`, in, 1: pulse when the player overlaps the can.
- `failed`, in, 1: pulse from the mover when the can passes the bottom limit.
- `initialX`, out, 11: lane X for the mover.
- `moverResetN`, out, 1: active-low reset to the mover.
- `gasolineVisible`, out, 1: draw enable for the can.
- `fuelLevel`, out, 8: current fuel.
- `fuelEmpty`, out, 1: `fuelLevel == 0`.
- `missCount`, out, 4: cans missed. Saturates at 15.

## Operation
- **FSM states:** IDLE, WAIT_SPAWN, LAUNCH, ACTIVE, CLEAR.
- **IDLE:** frame counter = 0. Goes to WAIT_SPAWN when `gameActive` = 1.
- **WAIT_SPAWN:** frame counter increments on each `startOfFrame`. The pulse that brings the count to `SPAWN_DELAY_FRAMES` moves the FSM to LAUNCH.
- **LAUNCH (one cycle):**
  - Lane index = `lfsr[1:0]`.
  - `initialX` loads the matching `LANE_Xn`.
  - Frame counter cleared.
  - Next state ACTIVE.
- **ACTIVE:**
  - `collected` → fuel refill, go to CLEAR.
  - `failed` (without `collected`) → `missCount`+1 saturating, go to CLEAR.
  - Both in the same cycle → treated as `collected` only.
- **CLEAR (one cycle):** frame counter = 0, next state WAIT_SPAWN.
- **`gameActive` = 0 in any state:**
  - Next state IDLE.
  - Fuel drain counter holds.
  - Fuel and `missCount` hold.
- **LFSR:**
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Advances every clock, independent of FSM state, so lane choice depends on player timing.
- **Fuel drain:**
  - While `gameActive` = 1 and fuel > 0, the drain counter counts `startOfFrame`.
  - On reaching `FUEL_DRAIN_FRAMES`, the counter clears and fuel decrements by 1.
  - Fuel never underflows.
- **Refill:** fuel = min(fuel + `FUEL_REFILL`, `FUEL_MAX`), computed 9-bit before saturation.
- **Drain and refill in the same cycle:** fuel = min(fuel − 1 + `FUEL_REFILL`, `FUEL_MAX`), computed in 9 bits.
- **`fuelEmpty`:** decoded from the fuel register. Fuel 0 does not stop spawning; the game controller decides game-over.
- **`collected`/`failed` outside ACTIVE:** ignored.

## Timing
- **Reset values (all registered outputs):**
  - `initialX` = `LANE_X0`
  - `moverResetN` = 0
  - `gasolineVisible` = 0
  - `fuelLevel` = `FUEL_MAX`
  - `fuelEmpty` = 0
  - `missCount` = 0
  - FSM = IDLE, both counters = 0, LFSR = seed
- **Registered outputs, derived from state:**
  - `moverResetN` = 1 only when the state is ACTIVE; 0 in all other states.
  - `gasolineVisible` = 1 only when the state is ACTIVE.
  - Both rise the cycle after LAUNCH and fall the cycle after the ending `collected`/`failed`.
- **`initialX`:** updated only on the LAUNCH→ACTIVE edge. Stable for the whole ACTIVE period, and already valid while `moverResetN` is low.
- **Launch latency:** the `startOfFrame` that completes the spawn delay is cycle N. LAUNCH is N+1. `moverResetN` and `gasolineVisible` are high from N+2.
- **Pickup to fuel update:** the `fuelLevel` update is visible the cycle after the `collected` pulse.
- **Reset priority:** reset mid-operation overrides everything, including a simultaneous `collected`/`failed`/`startOfFrame`.

## Test plan
- **Basic launch:** reset, `gameActive` = 1, `SPAWN_DELAY_FRAMES` = 3, `startOfFrame` every 10 clocks.
  - LAUNCH one cycle after the 3rd pulse.
  - `moverResetN` and `gasolineVisible` high from the next cycle.
  - `initialX` ∈ {200, 264, 328, 392} and equal to `LANE_X[lfsr[1:0]]` as sampled in LAUNCH.
- **Pickup refill:** fuel = 90, `collected` in ACTIVE.
  - `fuelLevel` = 100 (saturated).
  - Visible drops next cycle.
  - Relaunch after 3 more frames.
- **Miss:** `failed` in ACTIVE, 16 times.
  - `missCount` reaches 15 and holds.
  - Fuel unchanged.
- **Collision priority:** `collected` and `failed` in the same cycle → refill applied, `missCount` unchanged.
- **Drain:** `FUEL_DRAIN_FRAMES` = 2, start from fuel 3, give 6 frames with no pickups.
  - `fuelLevel` 3 → 2 → 1 → 0.
  - `fuelEmpty` = 1, stays 0 with no wrap.
  - Then a drain frame coinciding with `collected` at fuel 5 → `fuelLevel` 29.
- **Park and reset:** drop `gameActive` in ACTIVE → IDLE, `moverResetN` = 0, fuel held. Then assert `reset` mid-WAIT_SPAWN → every output returns to its reset value on the next edge.
